gate_sensor_decoder: RTL and testbench
======================================

# gate_sensor_decoder

Front end of the parking-lot occupancy path. It watches the two beam-break sensors at the lot gate, sensor A on the street side and sensor B on the lot side. It decodes the order in which they break and clear into single-cycle increment/decrement commands on `inc_dec`, which feeds `Occupancy_Counter` directly. Only complete, ordered passages produce commands; partial entries, reversals and glitches never produce a command.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a filtered sensor value changes. Used only when `GATE_DEBOUNCE_EN` is defined. Legal range 2..255.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `sensor_a`  input  1: street-side beam, 1 = blocked; asynchronous to `clk`.
- `sensor_b`  input  1: lot-side beam, 1 = blocked; asynchronous to `clk`.
- `inc_dec`  output  2: registered command. 2'b10 = increment, 2'b01 = decrement, 2'b00 = idle. 2'b11 is never driven.
- `fault`  output  1: registered one-cycle pulse on an illegal sensor transition.
- `busy`  output  1: registered; 1 whenever the FSM is not in IDLE.

## Operation
- Each sensor passes through a 2-flop synchronizer. With `GATE_DEBOUNCE_EN` defined, it then passes through the debounce filter. The result is the filtered pair `{a,b}`.
- The FSM steps on `{a,b}` once per cycle. It has states IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A and CLEAR_WAIT.
- Entry path:
  - IDLE with `10` goes to IN_A.
  - IN_A with `11` goes to IN_AB.
  - IN_AB with `01` goes to IN_B.
  - IN_B with `00` goes to IDLE and registers `inc_dec` = 2'b10.
- Exit path:
  - IDLE with `01` goes to OUT_B.
  - OUT_B with `11` goes to OUT_BA.
  - OUT_BA with `10` goes to OUT_A.
  - OUT_A with `00` goes to IDLE and registers `inc_dec` = 2'b01.
- Reversals are legal and emit no command:
  - IN_A with `00` goes to IDLE.
  - IN_AB with `10` goes to IN_A.
  - IN_B with `11` goes to IN_AB.
  - The exit path mirrors these reversals.
- An unchanged `{a,b}` holds the current state.
- Illegal transitions go to CLEAR_WAIT and pulse `fault`. An illegal transition is any two-bit jump (`00`↔`11`, `10`↔`01`) or any neighbour code not listed above.
- CLEAR_WAIT goes to IDLE on `00` and emits nothing. Staying in CLEAR_WAIT never pulses `fault` again.
- Reset puts the FSM in CLEAR_WAIT and sets the synchronizer and filter flops to 1 (blocked). A car present at reset release is therefore never half-counted, and the block counts again only after a real `00` arrives.
- Reset drives `inc_dec` = 2'b00, `fault` = 0 and `busy` = 1.
- `inc_dec` and `fault` are one-cycle pulses. Back-to-back passages produce separate pulses at least 4 cycles apart.

## Timing
- The synchronizer adds 2 cycles of latency; the FSM plus output register adds 1 cycle.
- Without the macro, `inc_dec` pulses in cycle 3 after the rising edge at which the final `00` is first presented on the raw pins.
- With the macro, add `DEBOUNCE_CYCLES` cycles.
- A reset asserted mid-passage takes effect immediately (asynchronous). An in-progress passage is dropped, and any pending pulse is suppressed.
- `busy` falls in the same cycle that `inc_dec` pulses.

## Configuration
- The macro is `GATE_DEBOUNCE_EN`.
- Defined: each synchronized sensor feeds a debounce filter.
  - The filter holds an 8-bit stability counter.
  - The filtered output takes the new value only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce back to the old value clears the counter.
- Undefined: the filtered value is the synchronizer output. No debounce logic is instantiated.

## Structure
- Shared package `occupancy_pkg` holds:
  - the `inc_dec` code constants: `CMD_IDLE` = 2'b00, `CMD_INC` = 2'b10, `CMD_DEC` = 2'b01;
  - the FSM state encoding, 3-bit, with 8 states.
- `Occupancy_Counter` imports the same command constants.
- Sub-module `sensor_debounce` contains one synchronizer plus filter per sensor and is instantiated twice. The filter section is guarded by `GATE_DEBOUNCE_EN`.

## Test plan
- Entry: drive `{a,b}` = 10, 11, 01, 00, holding each for 10 cycles, with no debounce. Required: exactly one `inc_dec` = 2'b10 pulse, 3 cycles after `00`; `busy` low afterwards.
- Exit: drive 01, 11, 10, 00. Required: exactly one 2'b01 pulse, and `fault` stays 0.
- Reversal: drive 10, 11, 10, 00. Required: no `inc_dec` pulse, no `fault`, FSM back in IDLE.
- Illegal jump: from IDLE drive 00 directly to 11. Required: one `fault` pulse and no command. Then 11, 01, 00 produces nothing; a following full entry produces 2'b10.
- Reset mid-passage: assert `reset` while in IN_AB, release while `{a,b}` = 01, then drive 00. Required: `inc_dec` stays 00 throughout, and the next full exit yields 2'b01.
- Debounce, with `GATE_DEBOUNCE_EN` and `DEBOUNCE_CYCLES` = 4: toggle `sensor_a` with 2-cycle glitches while idle. Required: no state change. A clean entry yields 2'b10 7 cycles after `00`.

Source files
------------

// File: rtl/occupancy_pkg.sv
// Shared definitions for the parking-lot occupancy path: inc_dec command
// codes (also used by Occupancy_Counter) and the gate FSM state encoding.
package occupancy_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b10;
  localparam logic [1:0] CMD_DEC  = 2'b01;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_IN_A       = 3'd1;
  localparam logic [2:0] ST_IN_AB      = 3'd2;
  localparam logic [2:0] ST_IN_B       = 3'd3;
  localparam logic [2:0] ST_OUT_B      = 3'd4;
  localparam logic [2:0] ST_OUT_BA     = 3'd5;
  localparam logic [2:0] ST_OUT_A      = 3'd6;
  localparam logic [2:0] ST_CLEAR_WAIT = 3'd7;

endpackage

// File: rtl/sensor_debounce.sv
// One beam sensor conditioner: 2-flop synchronizer, followed by a stability
// filter when GATE_DEBOUNCE_EN is defined. All flops reset to 1 (blocked) so
// a car standing in the beam at reset release is not treated as a passage.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..255");
  end

  logic sync_p0;
  logic sync_p1;

  // stage p0/p1: metastability synchronizer for the asynchronous beam input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef GATE_DEBOUNCE_EN
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       filt_p2;
  logic [7:0] stable_cnt;

  // stage p2: accept a new level only after it persists; any bounce restarts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_p2    <= 1'b1;
      stable_cnt <= 8'd0;
    end else if (sync_p1 != filt_p2) begin
      if (stable_cnt == CNT_LAST) begin
        filt_p2    <= sync_p1;
        stable_cnt <= 8'd0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end else begin
      stable_cnt <= 8'd0;
    end
  end

  assign filt = filt_p2;
`else
  assign filt = sync_p1;
`endif

endmodule

// File: rtl/gate_sensor_decoder.sv
// Gate sensor decoder: turns the break/clear order of the street-side (A) and
// lot-side (B) beams into one-cycle increment/decrement commands. Partial
// passages and reversals emit nothing; two-bit jumps pulse fault and park the
// FSM in CLEAR_WAIT until both beams read clear.
// Optional feature macro: GATE_DEBOUNCE_EN (adds a per-sensor debounce filter).
module gate_sensor_decoder
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [1:0] inc_dec,
  output logic       fault,
  output logic       busy
);

  logic       a_filt;
  logic       b_filt;
  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] cmd_nxt;
  logic       fault_nxt;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (sensor_a),
    .filt  (a_filt)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (sensor_b),
    .filt  (b_filt)
  );

  // Returns {next_state, command, fault}. An unchanged code falls through to
  // the defaults (hold, idle, no fault); every single-bit neighbour is a legal
  // step or reversal, so only two-bit jumps are faults.
  function automatic logic [5:0] fsm_step(input logic [2:0] st, input logic [1:0] ab);
    logic [2:0] nxt;
    logic [1:0] cmd;
    logic       flt;
    nxt = st;
    cmd = CMD_IDLE;
    flt = 1'b0;
    case (st)
      ST_IDLE: begin
        case (ab)
          2'b10:   nxt = ST_IN_A;
          2'b01:   nxt = ST_OUT_B;
          2'b11:   begin nxt = ST_CLEAR_WAIT; flt = 1'b1; end
          default: ;
        endcase
      end
      ST_IN_A: begin
        case (ab)
          2'b11:   nxt = ST_IN_AB;
          2'b00:   nxt = ST_IDLE;
          2'b01:   begin nxt = ST_CLEAR_WAIT; flt = 1'b1; end
          default: ;
        endcase
      end
      ST_IN_AB: begin
        case (ab)
          2'b01:   nxt = ST_IN_B;
          2'b10:   nxt = ST_IN_A;
          2'b00:   begin nxt = ST_CLEAR_WAIT; flt = 1'b1; end
          default: ;
        endcase
      end
      ST_IN_B: begin
        case (ab)
          2'b00:   begin nxt = ST_IDLE; cmd = CMD_INC; end
          2'b11:   nxt = ST_IN_AB;
          2'b10:   begin nxt = ST_CLEAR_WAIT; flt = 1'b1; end
          default: ;
        endcase
      end
      ST_OUT_B: begin
        case (ab)
          2'b11:   nxt = ST_OUT_BA;
          2'b00:   nxt = ST_IDLE;
          2'b10:   begin nxt = ST_CLEAR_WAIT; flt = 1'b1; end
          default: ;
        endcase
      end
      ST_OUT_BA: begin
        case (ab)
          2'b10:   nxt = ST_OUT_A;
          2'b01:   nxt = ST_OUT_B;
          2'b00:   begin nxt = ST_CLEAR_WAIT; flt = 1'b1; end
          default: ;
        endcase
      end
      ST_OUT_A: begin
        case (ab)
          2'b00:   begin nxt = ST_IDLE; cmd = CMD_DEC; end
          2'b11:   nxt = ST_OUT_BA;
          2'b01:   begin nxt = ST_CLEAR_WAIT; flt = 1'b1; end
          default: ;
        endcase
      end
      ST_CLEAR_WAIT: begin
        if (ab == 2'b00) nxt = ST_IDLE;
      end
      default: nxt = ST_CLEAR_WAIT;
    endcase
    return {nxt, cmd, flt};
  endfunction

  always_comb begin
    {state_nxt, cmd_nxt, fault_nxt} = fsm_step(state, {a_filt, b_filt});
  end

  // FSM + output register stage: commands, fault and busy are all registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR_WAIT;
      inc_dec <= CMD_IDLE;
      fault   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nxt;
      inc_dec <= cmd_nxt;
      fault   <= fault_nxt;
      busy    <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Scoreboard bench for gate_sensor_decoder: directed passages push expected
// pulses (kind + cycle) and output snapshots into queues; one monitor process
// compares them against the DUT on the falling clock edge.
module tb_gate_sensor_decoder;

`ifdef GATE_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  localparam logic [2:0] EV_INC   = 3'b100;
  localparam logic [2:0] EV_DEC   = 3'b010;
  localparam logic [2:0] EV_FAULT = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [1:0] inc;
    logic       flt;
    logic       bsy;
    string      name;
  } chk_t;

  logic       clk;
  logic       reset;
  logic       sensor_a;
  logic       sensor_b;
  logic [1:0] inc_dec;
  logic       fault;
  logic       busy;

  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   done;
  ev_t  evq[$];
  chk_t chkq[$];

  gate_sensor_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .inc_dec  (inc_dec),
    .fault    (fault),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive {a,b} at a falling edge and hold it; optionally expect a pulse LAT
  // rising edges after the first edge that samples the new value.
  task automatic drive(input logic [1:0] ab, input int hold, input logic [2:0] kind);
    ev_t e;
    @(negedge clk);
    sensor_a = ab[1];
    sensor_b = ab[0];
    if (kind != 3'b000) begin
      e.cyc  = cyc + LAT;
      e.kind = kind;
      evq.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  // Expect an output snapshot at the next falling edge.
  task automatic expect_outputs(input string name, input logic [1:0] inc, input logic flt,
                                input logic bsy);
    chk_t c;
    c.cyc  = cyc + 1;
    c.inc  = inc;
    c.flt  = flt;
    c.bsy  = bsy;
    c.name = name;
    chkq.push_back(c);
  endtask

  // Monitor: snapshot checks, pulse scoreboard, overdue pulses, final summary
  always @(negedge clk) begin
    chk_t c;
    ev_t  e;
    if (!done) begin
      if (chkq.size() > 0 && chkq[0].cyc == cyc) begin
        c = chkq.pop_front();
        n_checks++;
        if (inc_dec !== c.inc || fault !== c.flt || busy !== c.bsy) begin
          n_fail++;
          $display("FAIL %s: got inc_dec=%b fault=%b busy=%b, expected inc_dec=%b fault=%b busy=%b",
                   c.name, inc_dec, fault, busy, c.inc, c.flt, c.bsy);
        end
      end
      if (!reset && (inc_dec !== 2'b00 || fault !== 1'b0)) begin
        n_checks++;
        if (evq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got inc_dec=%b fault=%b at cycle %0d, expected no pulse",
                   inc_dec, fault, cyc);
        end else begin
          e = evq.pop_front();
          if ({inc_dec, fault} !== e.kind || cyc != e.cyc ||
              (inc_dec !== 2'b00 && busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL pulse: got {inc_dec,fault}=%b busy=%b at cycle %0d, expected %b busy=0 at cycle %0d",
                     {inc_dec, fault}, busy, cyc, e.kind, e.cyc);
          end
        end
      end
      if (evq.size() > 0 && cyc > evq[0].cyc) begin
        e = evq.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse: got nothing by cycle %0d, expected %b at cycle %0d",
                 cyc, e.kind, e.cyc);
      end
    end else begin
      n_checks++;
      if (evq.size() != 0 || chkq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got %0d pulses and %0d snapshots pending, expected 0",
                 evq.size(), chkq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done     = 1'b0;
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (2) @(negedge clk);
    expect_outputs("reset_state", 2'b00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    expect_outputs("idle_after_reset", 2'b00, 1'b0, 1'b0);

    // Entry passage
    drive(2'b10, 10, 3'b000);
    expect_outputs("entry_busy", 2'b00, 1'b0, 1'b1);
    drive(2'b11, 10, 3'b000);
    drive(2'b01, 10, 3'b000);
    drive(2'b00, 10, EV_INC);
    expect_outputs("entry_done_idle", 2'b00, 1'b0, 1'b0);

    // Exit passage
    drive(2'b01, 10, 3'b000);
    drive(2'b11, 10, 3'b000);
    drive(2'b10, 10, 3'b000);
    drive(2'b00, 10, EV_DEC);
    expect_outputs("exit_done_idle", 2'b00, 1'b0, 1'b0);

    // Reversal back out of the entry path
    drive(2'b10, 10, 3'b000);
    drive(2'b11, 10, 3'b000);
    drive(2'b10, 10, 3'b000);
    drive(2'b00, 10, 3'b000);
    expect_outputs("reversal_idle", 2'b00, 1'b0, 1'b0);

    // Illegal two-bit jump from IDLE, then recovery
    drive(2'b11, 10, EV_FAULT);
    expect_outputs("clear_wait_busy", 2'b00, 1'b0, 1'b1);
    drive(2'b11, 10, 3'b000);
    drive(2'b01, 10, 3'b000);
    drive(2'b00, 10, 3'b000);
    expect_outputs("recovered_idle", 2'b00, 1'b0, 1'b0);
    drive(2'b10, 10, 3'b000);
    drive(2'b11, 10, 3'b000);
    drive(2'b01, 10, 3'b000);
    drive(2'b00, 10, EV_INC);

    // Reset in the middle of an entry (FSM in IN_AB)
    drive(2'b10, 10, 3'b000);
    drive(2'b11, 10, 3'b000);
    @(negedge clk);
    sensor_a = 1'b0;
    sensor_b = 1'b1;
    #1 reset = 1'b1;
    expect_outputs("midpass_reset", 2'b00, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    expect_outputs("post_reset_wait", 2'b00, 1'b0, 1'b1);
    drive(2'b00, 10, 3'b000);
    expect_outputs("post_reset_idle", 2'b00, 1'b0, 1'b0);
    drive(2'b01, 10, 3'b000);
    drive(2'b11, 10, 3'b000);
    drive(2'b10, 10, 3'b000);
    drive(2'b00, 10, EV_DEC);

`ifdef GATE_DEBOUNCE_EN
    // Short glitches on sensor_a must not reach the FSM
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 2, 3'b000);
      drive(2'b00, 8, 3'b000);
    end
    expect_outputs("glitch_idle", 2'b00, 1'b0, 1'b0);
    drive(2'b10, 10, 3'b000);
    drive(2'b11, 10, 3'b000);
    drive(2'b01, 10, 3'b000);
    drive(2'b00, 10, EV_INC);
`endif

    repeat (12) @(negedge clk);
    done = 1'b1;
  end

endmodule
